// File: rtl/sd_bd_queue.sv
// sd_bd_queue: buffer-descriptor queue between a host writer and a data-master
// reader. Each BD is two 32-bit words (system address, command argument).
// Host writes one word per strobe; a BD becomes visible to the reader only once
// its second word lands. The reader fetches the two words with a small FSM and
// the data master returns slots with a_cmp once it has consumed the oldest BD.
//
// Handshake: re_s is a level request held for the whole BD; each word is
// presented for exactly one cycle with ack_o_s high and dat_out_s valid in
// that same cycle. There is no back-pressure on ack_o_s; the master must take
// the word when it sees ack_o_s. we_m and a_cmp are single-cycle strobes that
// are either accepted or reported by a one-cycle wr_ovf / cmp_err pulse.
//
// The dbg_* outputs expose read FSM state and both pointers for observation.
module sd_bd_queue #(
  parameter int BD_SIZE  = 16,
  parameter int BD_WIDTH = 5,
  localparam int PTR_W   = $clog2(BD_SIZE),
  localparam int BD_EMPTY = BD_SIZE / 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bd_clr,
  input  logic                we_m,
  input  logic [31:0]         dat_in_m,
  output logic                wr_ovf,
  output logic [BD_WIDTH-1:0] free_bd,
  input  logic                re_s,
  output logic                ack_o_s,
  output logic [31:0]         dat_out_s,
  input  logic                a_cmp,
  output logic                cmp_err,
  output logic [2:0]          dbg_rd_state,
  output logic [PTR_W-1:0]    dbg_wr_ptr,
  output logic [PTR_W-1:0]    dbg_rd_ptr
);

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_FETCH = 3'd1,
    R_ACK   = 3'd2,
    R_GAP   = 3'd3,
    R_HOLD  = 3'd4
  } rd_state_e;

  localparam logic [BD_WIDTH-1:0] BD_EMPTY_V = BD_WIDTH'(BD_EMPTY);

  logic [31:0]         mem_q [BD_SIZE];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic                wr_half_q;
  logic                rd_word_q;
  logic [BD_WIDTH-1:0] free_bd_q;
  logic [BD_WIDTH-1:0] unread_q;
  logic                wr_ovf_q;
  logic                cmp_err_q;
  logic                ack_q;
  logic [31:0]         dat_out_q;
  rd_state_e           rd_state_q;

  logic wr_accept;
  logic bd_commit;
  logic cmp_ok;
  logic bd_read_done;

  // A word is accepted while any slot is free; the second word commits the BD.
  // a_cmp on an empty queue is only harmless when a commit refills it this cycle.
  always_comb begin
    wr_accept    = we_m && (free_bd_q != '0);
    bd_commit    = wr_accept && wr_half_q;
    cmp_ok       = a_cmp && ((free_bd_q != BD_EMPTY_V) || bd_commit);
    bd_read_done = (rd_state_q == R_ACK) && rd_word_q;
  end

  // Storage array: written by the host port, no reset (contents undefined).
  always_ff @(posedge clk) begin
    if (wr_accept && !rst && !bd_clr) begin
      mem_q[wr_ptr_q] <= dat_in_m;
    end
  end

  // Write pointer, free-slot accounting and the error pulses.
  always_ff @(posedge clk) begin
    if (rst || bd_clr) begin
      wr_ptr_q  <= '0;
      wr_half_q <= 1'b0;
      free_bd_q <= BD_EMPTY_V;
      wr_ovf_q  <= 1'b0;
      cmp_err_q <= 1'b0;
    end else begin
      wr_ovf_q  <= we_m && !wr_accept;
      cmp_err_q <= a_cmp && !cmp_ok;
      if (wr_accept) begin
        wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
        wr_half_q <= ~wr_half_q;
      end
      if (bd_commit && !cmp_ok) begin
        free_bd_q <= free_bd_q - BD_WIDTH'(1);
      end else if (cmp_ok && !bd_commit) begin
        free_bd_q <= free_bd_q + BD_WIDTH'(1);
      end
    end
  end

  // Read FSM with registered ack/data; also counts committed-but-unread BDs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_ptr_q   <= '0;
      rd_word_q  <= 1'b0;
      unread_q   <= '0;
      ack_q      <= 1'b0;
      dat_out_q  <= '0;
    end else if (bd_clr) begin
      // Flush keeps the last delivered word on dat_out_s.
      rd_state_q <= R_IDLE;
      rd_ptr_q   <= '0;
      rd_word_q  <= 1'b0;
      unread_q   <= '0;
      ack_q      <= 1'b0;
    end else begin
      if (bd_commit && !bd_read_done) begin
        unread_q <= unread_q + BD_WIDTH'(1);
      end else if (bd_read_done && !bd_commit) begin
        unread_q <= unread_q - BD_WIDTH'(1);
      end
      ack_q <= 1'b0;
      case (rd_state_q)
        R_IDLE: begin
          if (re_s && (unread_q != '0)) begin
            rd_state_q <= R_FETCH;
          end
        end
        R_FETCH: begin
          ack_q      <= 1'b1;
          dat_out_q  <= mem_q[rd_ptr_q];
          rd_state_q <= R_ACK;
        end
        R_ACK: begin
          rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
          rd_word_q  <= ~rd_word_q;
          rd_state_q <= rd_word_q ? R_HOLD : R_GAP;
        end
        R_GAP: begin
          if (re_s) begin
            rd_state_q <= R_FETCH;
          end else begin
            // Master gave up mid-BD: rewind so the next request restarts at word0.
            rd_ptr_q   <= rd_ptr_q - PTR_W'(1);
            rd_word_q  <= 1'b0;
            rd_state_q <= R_IDLE;
          end
        end
        R_HOLD: begin
          if (!re_s) begin
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign wr_ovf       = wr_ovf_q;
  assign cmp_err      = cmp_err_q;
  assign free_bd      = free_bd_q;
  assign ack_o_s      = ack_q;
  assign dat_out_s    = dat_out_q;
  assign dbg_rd_state = rd_state_q;
  assign dbg_wr_ptr   = wr_ptr_q;
  assign dbg_rd_ptr   = rd_ptr_q;

endmodule

// File: doc/sd_bd_queue.md
SD_BD_QUEUE -- requirements
Module: sd_bd_queue

Interface
REQ-001 Parameter: BD_SIZE, 16, queue storage depth in 32-bit words; each buffer descriptor (BD) is 2 words (word0 = system address, word1 = command argument).
REQ-002 Parameter: BD_WIDTH, 5, width of free_bd.
REQ-003 Derived constant BD_EMPTY = BD_SIZE/2 (8), the free count of an empty queue.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 bd_clr  input  1  synchronous queue flush.
REQ-007 we_m  input  1  host write strobe, one word per high cycle.
REQ-008 dat_in_m  input  32  host write data.
REQ-009 wr_ovf  output  1  one-cycle pulse, host word dropped.
REQ-010 free_bd  output  BD_WIDTH  number of free BD slots.
REQ-011 re_s  input  1  data-master read request, level, held across a BD read.
REQ-012 ack_o_s  output  1  one-cycle read acknowledge; dat_out_s valid while high.
REQ-013 dat_out_s  output  32  BD word to data master.
REQ-014 a_cmp  input  1  one-cycle pulse, data master finished with oldest read BD.
REQ-015 cmp_err  output  1  one-cycle pulse, a_cmp received with nothing to free.

Function
REQ-016 Storage: BD_SIZE x 32 array; wr_ptr, rd_ptr log2(BD_SIZE) bits, wrap BD_SIZE-1 -> 0.
REQ-017 Host write: we_m accepted when free_bd != 0; word stored at wr_ptr; wr_ptr++; wr_half toggles.
REQ-018 Commit: acceptance of word1 (wr_half=1) commits the BD; free_bd decrements by 1 on the following edge; a half-written BD is never counted and never read.
REQ-019 we_m with free_bd == 0: word dropped, pointers unchanged, wr_ovf = 1 next cycle.
REQ-020 Read FSM states: R_IDLE, R_FETCH, R_ACK, R_GAP, R_HOLD.
REQ-021 R_IDLE -> R_FETCH when re_s = 1 and at least one committed BD is unread; otherwise stay.
REQ-022 R_FETCH: array read at rd_ptr; -> R_ACK.
REQ-023 R_ACK: ack_o_s = 1, dat_out_s = fetched word; rd_ptr++; rd_word toggles; -> R_GAP if it was word0, -> R_HOLD if it was word1.
REQ-024 R_GAP: ack_o_s = 0; re_s = 1 -> R_FETCH; re_s = 0 -> abort: rd_ptr rewinds to BD start (rd_ptr-1), rd_word = 0, -> R_IDLE.
REQ-025 R_HOLD: ack_o_s = 0; stays until re_s = 0, then -> R_IDLE; never more than 2 acks per BD.
REQ-026 Latency: re_s high sampled in R_IDLE at edge N -> ack word0 in cycle N+2, ack word1 in cycle N+5; at least one non-ack cycle between acks.
REQ-027 dat_out_s holds its last value outside R_ACK.
REQ-028 a_cmp: free_bd increments by 1 on the following edge.
REQ-029 a_cmp and BD commit in the same cycle: free_bd unchanged.
REQ-030 a_cmp with free_bd == BD_EMPTY and no commit that cycle: ignored, cmp_err = 1 next cycle.
REQ-031 free_bd never exceeds BD_EMPTY and never underflows below 0.
REQ-032 Host writes and master reads proceed concurrently; the write port never targets an unread committed word.

Reset
REQ-033 rst = 1: free_bd = BD_EMPTY, wr_ptr = rd_ptr = 0, wr_half = rd_word = 0, FSM = R_IDLE, ack_o_s = 0, dat_out_s = 0, wr_ovf = 0, cmp_err = 0; array contents undefined.
REQ-034 bd_clr = 1: same as rst, except dat_out_s holds; aborts any read or half-written BD mid-operation.
REQ-035 Priority: rst > bd_clr > a_cmp/we_m/read FSM.

Verification
REQ-036 Reset, write 0x1000_0000 then 0x0000_0040 -> free_bd 8 -> 7; re_s held high -> ack_o_s at N+2 with 0x1000_0000 and N+5 with 0x0000_0040; no third ack.
REQ-037 Write 8 BDs -> free_bd = 0; a 17th word -> wr_ovf pulse, free_bd stays 0; a_cmp -> free_bd = 1; a further 2 words -> free_bd = 0, wr_ptr wrapped to 2.
REQ-038 Single word written, re_s high -> no ack (half BD invisible); second word -> ack sequence starts.
REQ-039 re_s dropped in R_GAP after word0 -> next re_s rereads same BD starting at word0.
REQ-040 a_cmp with free_bd = 8 -> cmp_err pulse, free_bd stays 8; a_cmp coincident with a commit -> free_bd unchanged.
REQ-041 bd_clr asserted during R_GAP with 3 BDs queued -> ack_o_s = 0, free_bd = 8, FSM R_IDLE next cycle.
